multicycle_ri_cpu: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle R/I-type CPU top.
- Runs a MIPS-32 R/I/J subset through an explicit IF/ID/EX/MEM/WB state machine.
- Contains its own 32x32 register file and ALU.
- Reaches instruction and data memories through req/ready handshake ports, so memories with wait states plug in directly.

---
 rtl/multicycle_ri_cpu.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_ri_cpu.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ri_cpu.sv
// multicycle_ri_cpu: MIPS-32 R/I/J subset CPU with IF/ID/EX/MEM/WB FSM and req/ready memory ports
module multicycle_ri_cpu #(
  parameter int          IM_AW    = 6,
  parameter int          DM_AW    = 6,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  output logic             im_req,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_rdata,
  input  logic             im_ready,
  output logic             dm_req,
  output logic             dm_we,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_wdata,
  input  logic [31:0]      dm_rdata,
  input  logic             dm_ready,
  output logic [31:0]      F,
  output logic             ZF,
  output logic             OF,
  output logic [31:0]      pc,
  output logic             instr_done,
  output logic             halt
);
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, f_q, f_d, mdr_q, mdr_d;
  logic        zf_q, zf_d, of_q, of_d, halt_q, halt_d, im_req_q, im_req_d, dm_req_q, dm_req_d;
  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [5:0]  op, funct, k;
  logic [15:0] imm;
  logic [31:0] sext, bop, sum, diff, alu_f;
  logic        is_r, is_br, is_j, is_mem, is_sw, is_lw, legal, ovf, taken;
  assign op     = ir_q[31:26];
  assign funct  = ir_q[5:0];
  assign imm    = ir_q[15:0];
  assign sext   = {{16{imm[15]}}, imm};
  assign is_r   = op == 6'h00;
  assign is_br  = op == 6'h04 || op == 6'h05;
  assign is_j   = op == 6'h02;
  assign is_lw  = op == 6'h23;
  assign is_sw  = op == 6'h2B;
  assign is_mem = is_lw || is_sw;
  assign legal  = is_r ? (funct == 6'h20 || funct == 6'h22 || (funct >= 6'h24 && funct <= 6'h27) ||
                          funct == 6'h2A || funct == 6'h2B)
                       : (op == 6'h08 || op == 6'h0A || (op >= 6'h0C && op <= 6'h0F) ||
                          is_mem || is_br || is_j);
  // I-type opcodes are folded onto the R-type funct that performs the same ALU op; 3F marks lui
  always_comb begin
    k = 6'h00;
    case (op)
      6'h00:               k = funct;
      6'h08, 6'h23, 6'h2B: k = 6'h20;
      6'h04, 6'h05:        k = 6'h22;
      6'h0A:               k = 6'h2A;
      6'h0C:               k = 6'h24;
      6'h0D:               k = 6'h25;
      6'h0E:               k = 6'h26;
      6'h0F:               k = 6'h3F;
      default:             k = 6'h00;
    endcase
  end
  assign bop   = (is_r || is_br) ? b_q : (op >= 6'h0C && op <= 6'h0E) ? {16'h0, imm} : sext;
  assign sum   = a_q + bop;
  assign diff  = a_q - bop;
  assign alu_f = k == 6'h20 ? sum :
                 k == 6'h22 ? diff :
                 k == 6'h24 ? a_q & bop :
                 k == 6'h25 ? a_q | bop :
                 k == 6'h26 ? a_q ^ bop :
                 k == 6'h27 ? ~(a_q | bop) :
                 k == 6'h2A ? {31'h0, $signed(a_q) < $signed(bop)} :
                 k == 6'h2B ? {31'h0, a_q < bop} : {imm, 16'h0};
  assign ovf   = (is_r || op == 6'h08) &&
                 (k == 6'h20 ? (a_q[31] == bop[31] && sum[31] != a_q[31]) :
                  k == 6'h22 ? (a_q[31] != bop[31] && diff[31] != a_q[31]) : 1'b0);
  assign taken = (op == 6'h04) ? (diff == 32'h0) : (diff != 32'h0);
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    f_d      = f_q;
    zf_d     = zf_q;
    of_d     = of_q;
    mdr_d    = mdr_q;
    halt_d   = halt_q;
    im_req_d = im_req_q;
    dm_req_d = dm_req_q;
    rf_we    = 1'b0;
    rf_wa    = is_r ? ir_q[15:11] : ir_q[20:16];
    rf_wd    = is_lw ? mdr_q : f_q;
    case (state_q)
      S_IF: begin
        im_req_d = 1'b1;
        if (im_req_q && im_ready) begin
          ir_d     = im_rdata;
          pc_d     = pc_q + 32'd4;
          im_req_d = 1'b0;
          state_d  = S_ID;
        end
      end
      S_ID: begin
        a_d     = rf_q[ir_q[25:21]];
        b_d     = rf_q[ir_q[20:16]];
        halt_d  = !legal;
        state_d = legal ? S_EX : S_HALT;
      end
      S_EX: begin
        if (is_j) begin
          pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
          im_req_d = 1'b1;
          state_d  = S_IF;
        end else begin
          f_d  = alu_f;
          zf_d = alu_f == 32'h0;
          of_d = is_br ? of_q : ovf;
          if (is_br) begin
            pc_d     = taken ? pc_q + {sext[29:0], 2'b00} : pc_q;
            im_req_d = 1'b1;
            state_d  = S_IF;
          end else if (is_mem) begin
            dm_req_d = 1'b1;
            state_d  = S_MEM;
          end else
            state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dm_req_q && dm_ready) begin
          dm_req_d = 1'b0;
          mdr_d    = dm_rdata;
          im_req_d = is_sw;
          state_d  = is_sw ? S_IF : S_WB;
        end
      end
      S_WB: begin
        rf_we    = rf_wa != 5'd0;
        im_req_d = 1'b1;
        state_d  = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IF;
      pc_q     <= PC_RESET;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      f_q      <= '0;
      zf_q     <= 1'b0;
      of_q     <= 1'b0;
      mdr_q    <= '0;
      halt_q   <= 1'b0;
      im_req_q <= 1'b0;
      dm_req_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      f_q      <= f_d;
      zf_q     <= zf_d;
      of_q     <= of_d;
      mdr_q    <= mdr_d;
      halt_q   <= halt_d;
      im_req_q <= im_req_d;
      dm_req_q <= dm_req_d;
      if (rf_we) rf_q[rf_wa] <= rf_wd;
    end
  end
  assign im_req     = im_req_q;
  assign im_addr    = pc_q[IM_AW+1:2];
  assign dm_req     = dm_req_q;
  assign dm_we      = is_sw;
  assign dm_addr    = f_q[DM_AW+1:2];
  assign dm_wdata   = b_q;
  assign F          = f_q;
  assign ZF         = zf_q;
  assign OF         = of_q;
  assign pc         = pc_q;
  assign halt       = halt_q;
  assign instr_done = state_q == S_WB || (state_q == S_EX && (is_br || is_j)) ||
                      (state_q == S_MEM && is_sw && dm_req_q && dm_ready);
endmodule

// File: tb/tb_multicycle_ri_cpu.sv
// tb_multicycle_ri_cpu: scoreboard bench; expected retire results are queued per program, a monitor checks each retire
module tb_multicycle_ri_cpu;
  logic        clk = 1'b0, rst = 1'b0;
  logic        im_req, im_ready, dm_req, dm_we, dm_ready, ZF, OF, instr_done, halt;
  logic [5:0]  im_addr, dm_addr;
  logic [31:0] im_rdata, dm_wdata, dm_rdata, F, pc;
  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic        force_ready = 1'b0;
  int          dm_delay = 3, checks = 0, failures = 0, cycle = 0;
  typedef struct {
    logic [31:0] pc, f;
    logic        zf, of, chk;
    logic [4:0]  r;
    logic [31:0] rv;
    int          cyc;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  assign im_ready = 1'b1;
  assign im_rdata = imem[im_addr];
  multicycle_ri_cpu #(.IM_AW(6), .DM_AW(6), .PC_RESET(32'h0)) dut (
    .clk(clk), .rst(rst), .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata), .im_ready(im_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_ready(dm_ready), .F(F), .ZF(ZF), .OF(OF), .pc(pc), .instr_done(instr_done), .halt(halt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask
  task automatic push(input logic [31:0] p, input logic [31:0] f, input logic zf, input logic of,
                      input logic c, input logic [4:0] r, input logic [31:0] rv, input int cyc);
    exp_t e;
    e.pc = p; e.f = f; e.zf = zf; e.of = of; e.chk = c; e.r = r; e.rv = rv; e.cyc = cyc;
    q.push_back(e);
  endtask
  initial forever begin
    @(posedge clk);
    cycle++;
  end
  // data memory: ready after dm_delay wait states, checks request signals stay put while waiting
  initial begin
    int cnt;
    logic [5:0] pa;
    logic [31:0] pw;
    logic pwe;
    cnt = 0; dm_ready = 1'b0; dm_rdata = '0; pa = '0; pw = '0; pwe = 1'b0;
    forever begin
      @(negedge clk);
      dm_ready = force_ready | (dm_req && cnt >= dm_delay);
      dm_rdata = dmem[dm_addr];
      if (dm_req && cnt > 0) begin
        chk("dm_addr_stable", {26'h0, dm_addr}, {26'h0, pa});
        chk("dm_wdata_stable", dm_wdata, pw);
        chk("dm_we_stable", {31'h0, dm_we}, {31'h0, pwe});
      end
      if (dm_ready && dm_req && dm_we && rst) dmem[dm_addr] = dm_wdata;
      pa = dm_addr; pw = dm_wdata; pwe = dm_we;
      cnt = dm_req ? cnt + 1 : 0;
    end
  end
  initial begin
    exp_t e;
    int last;
    last = 0;
    forever begin
      @(negedge clk);
      if (instr_done && rst) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_retire: got retire at pc %h expected none", pc);
        end else begin
          e = q.pop_front();
          if (e.cyc != 0) chk("retire_cycles", cycle - last, e.cyc);
          last = cycle;
          @(negedge clk);
          chk("pc", pc, e.pc);
          chk("F", F, e.f);
          chk("ZF", {31'h0, ZF}, {31'h0, e.zf});
          chk("OF", {31'h0, OF}, {31'h0, e.of});
          if (e.chk) chk($sformatf("reg%0d", e.r), dut.rf_q[e.r], e.rv);
        end
      end
    end
  end
  initial begin
    int n;
    logic seen;
    for (int i = 0; i < 64; i++) begin imem[i] = 32'hFC00_0000; dmem[i] = '0; end
    imem[0] = 32'h3401_7FFF; imem[1] = 32'h3C02_7FFF; imem[2] = 32'h0042_1820; imem[3] = 32'h0021_2022;
    imem[4] = 32'h0061_282A; imem[5] = 32'h0061_302B; imem[6] = 32'hAC01_0008; imem[7] = 32'h8C07_0008;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_F", F, 32'h0);
    chk("rst_flags", {27'h0, ZF, OF, halt, im_req, dm_req}, 32'h0);
    chk("rst_done", {31'h0, instr_done}, 32'h0);
    push(32'h04, 32'h0000_7FFF, 0, 0, 1, 1, 32'h0000_7FFF, 0);
    push(32'h08, 32'h7FFF_0000, 0, 0, 1, 2, 32'h7FFF_0000, 4);
    push(32'h0C, 32'hFFFE_0000, 0, 1, 1, 3, 32'hFFFE_0000, 4);
    push(32'h10, 32'h0,         1, 0, 1, 4, 32'h0,         4);
    push(32'h14, 32'h1,         0, 0, 1, 5, 32'h1,         4);
    push(32'h18, 32'h0,         1, 0, 1, 6, 32'h0,         4);
    push(32'h1C, 32'h8,         0, 0, 0, 0, 32'h0,         7);
    push(32'h20, 32'h8,         0, 0, 1, 7, 32'h0000_7FFF, 8);
    rst = 1'b1;
    n = 0;
    while (!dm_req && n < 300) begin @(negedge clk); n++; end
    chk("sw_req", {31'h0, dm_req}, 32'h1);
    chk("sw_we", {31'h0, dm_we}, 32'h1);
    chk("sw_addr", {26'h0, dm_addr}, 32'h2);
    chk("sw_wdata", dm_wdata, 32'h0000_7FFF);
    n = 0;
    while (!halt && n < 300) begin @(negedge clk); n++; end
    chk("halt_set", {31'h0, halt}, 32'h1);
    seen = 1'b0;
    repeat (20) begin @(negedge clk); seen |= im_req | dm_req; end
    chk("halt_no_req", {31'h0, seen}, 32'h0);
    chk("halt_pc", pc, 32'h24);
    chk("halt_sticky", {31'h0, halt}, 32'h1);
    chk("dmem_store", dmem[2], 32'h0000_7FFF);
    chk("queue_a_drained", q.size(), 32'h0);
    rst = 1'b0;
    dm_delay = 20;
    for (int i = 0; i < 64; i++) imem[i] = 32'hFC00_0000;
    imem[0]  = 32'h2001_FFFF; imem[1]  = 32'h3022_00F0; imem[2]  = 32'h2823_0000; imem[3]  = 32'h3844_FFFF;
    imem[4]  = 32'h1000_FFFF; imem[5]  = 32'h0022_2827; imem[6]  = 32'h0044_3025; imem[7]  = 32'h0082_3826;
    imem[8]  = 32'h0001_4022; imem[9]  = 32'h0021_0020; imem[10] = 32'h0800_000C; imem[12] = 32'h8C09_000C;
    repeat (2) @(negedge clk);
    chk("rst2_halt", {31'h0, halt}, 32'h0);
    chk("rst2_reg3", dut.rf_q[3], 32'h0);
    push(32'h04, 32'hFFFF_FFFF, 0, 0, 1, 1, 32'hFFFF_FFFF, 0);
    push(32'h08, 32'h0000_00F0, 0, 0, 1, 2, 32'h0000_00F0, 4);
    push(32'h0C, 32'h1,         0, 0, 1, 3, 32'h1,         4);
    push(32'h10, 32'h0000_FF0F, 0, 0, 1, 4, 32'h0000_FF0F, 4);
    push(32'h10, 32'h0,         1, 0, 0, 0, 32'h0,         3);
    push(32'h14, 32'h0,         1, 0, 0, 0, 32'h0,         3);
    push(32'h18, 32'h0,         1, 0, 1, 5, 32'h0,         4);
    push(32'h1C, 32'h0000_FFFF, 0, 0, 1, 6, 32'h0000_FFFF, 4);
    push(32'h20, 32'h0000_FFFF, 0, 0, 1, 7, 32'h0000_FFFF, 4);
    push(32'h24, 32'h1,         0, 0, 1, 8, 32'h1,         4);
    push(32'h28, 32'hFFFF_FFFE, 0, 0, 1, 0, 32'h0,         4);
    push(32'h30, 32'hFFFF_FFFE, 0, 0, 0, 0, 32'h0,         3);
    rst = 1'b1;
    // once beq has looped back, swap it for a not-taken bne
    n = 0;
    while (!(instr_done && pc == 32'h14) && n < 300) begin @(negedge clk); n++; end
    chk("beq_retire", {31'h0, instr_done}, 32'h1);
    imem[4] = 32'h1400_0004;
    n = 0;
    while (!dm_req && n < 300) begin @(negedge clk); n++; end
    chk("lw_req", {31'h0, dm_req}, 32'h1);
    chk("lw_addr", {26'h0, dm_addr}, 32'h3);
    chk("queue_b_drained", q.size(), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_dm_req", {31'h0, dm_req}, 32'h0);
    chk("mrst_pc", pc, 32'h0);
    chk("mrst_reg6", dut.rf_q[6], 32'h0);
    chk("mrst_reg8", dut.rf_q[8], 32'h0);
    force_ready = 1'b1;
    rst = 1'b1;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen |= dm_req | instr_done; end
    force_ready = 1'b0;
    chk("late_ready_ignored", {31'h0, seen}, 32'h0);
    chk("late_ready_reg9", dut.rf_q[9], 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
